// File: rtl/frame_parity_rx.sv
// rtl/frame_parity_rx.sv - parity-checked serial frame receiver with one-deep holding register
// Optional error counter enabled by defining FRAME_PARITY_RX_ERRCNT_EN.
module frame_parity_rx #(
  parameter int DATA_W     = 10,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              par_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
`ifdef FRAME_PARITY_RX_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int            CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] shreg;
  logic              par_q;
  logic              perr_q;
  logic              complete;
  logic              accept;
  logic              load;

  assign complete = bit_en && (state == ST_STOP);
  assign accept   = out_valid & out_ready;
  // A frame may land in the same cycle the consumer drains the previous one.
  assign load     = complete & (~out_valid | out_ready);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      shreg     <= '0;
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bit_en) begin
        case (state)
          ST_IDLE: begin
            if (!rx_bit) begin
              state <= ST_DATA;
              count <= '0;
              shreg <= '0;
              par_q <= (ODD_PARITY != 0);
            end
          end
          ST_DATA: begin
            // LSB-first shift: after DATA_W strobes the first bit sits at bit 0.
            shreg <= {rx_bit, shreg[DATA_W-1:1]};
            par_q <= par_q ^ rx_bit;
            count <= count + CW'(1);
            if (count == LAST) state <= ST_PARITY;
          end
          ST_PARITY: begin
            perr_q <= par_q ^ rx_bit;
            state  <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end

      if (load) begin
        out_data  <= shreg;
        par_err   <= perr_q;
        frame_err <= ~rx_bit;
        out_valid <= 1'b1;
      end else begin
        if (accept) out_valid <= 1'b0;
        if (complete) overrun <= 1'b1;
      end
    end
  end

`ifdef FRAME_PARITY_RX_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (complete && (perr_q || !rx_bit) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_parity_rx.sv
// tb/tb_frame_parity_rx.sv - directed table-driven bench for frame_parity_rx
// Checks err_count as well when FRAME_PARITY_RX_ERRCNT_EN is defined.
module tb_frame_parity_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       rx_bit;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       par_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef FRAME_PARITY_RX_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  frame_parity_rx #(.DATA_W(10), .ODD_PARITY(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .rx_bit    (rx_bit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .par_err   (par_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef FRAME_PARITY_RX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  typedef struct {
    logic [9:0] data;
    logic       pbit;
    logic       sbit;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_en = 1'b1;
    rx_bit = b;
    tick();
    bit_en = 1'b0;
    rx_bit = 1'b1;
  endtask

  task automatic gap(input int maxgap);
    if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
  endtask

  // start bit, data LSB first, parity bit; the stop bit is sent by the caller
  task automatic send_body(input logic [9:0] data, input logic p, input int maxgap);
    send_bit(1'b0);
    gap(maxgap);
    for (int i = 0; i < 10; i++) begin
      send_bit(data[i]);
      gap(maxgap);
    end
    send_bit(p);
    gap(maxgap);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_err = 0;
  endtask

  initial begin
    int vcnt;
    vecs[0] = '{10'h2A5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{10'h2A5, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{10'h001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{10'h3FF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{10'h001, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{10'h3FF, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b0; bit_en = 1'b0; rx_bit = 1'b1; out_ready = 1'b0;
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_perr", par_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);

    for (int v = 0; v < 7; v++) begin
      send_body(vecs[v].data, vecs[v].pbit, 0);
      chk("mid_busy", busy, 1);
      send_bit(vecs[v].sbit);
      if (vecs[v].exp_perr || vecs[v].exp_ferr) exp_err++;
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, vecs[v].data);
      chk("vec_perr", par_err, vecs[v].exp_perr);
      chk("vec_ferr", frame_err, vecs[v].exp_ferr);
      chk("vec_busy", busy, 0);
      tick();
      chk("vec_hold", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("vec_accept", out_valid, 0);
    end
    chk("vec_overrun", overrun, 0);
`ifdef FRAME_PARITY_RX_ERRCNT_EN
    chk("err_count", err_count, exp_err);
`endif

    // completion coincides with consumer accept
    send_body(10'h001, 1'b1, 0);
    send_bit(1'b1);
    chk("sim_first", out_data, 10'h001);
    send_body(10'h3FF, 1'b0, 0);
    out_ready = 1'b1;
    send_bit(1'b1);
    chk("sim_valid", out_valid, 1);
    chk("sim_data", out_data, 10'h3FF);
    chk("sim_overrun", overrun, 0);
    tick();
    out_ready = 1'b0;
    chk("sim_drain", out_valid, 0);

    // overrun: second frame dropped while holding register is full
    send_body(10'h2A5, 1'b1, 0);
    send_bit(1'b1);
    send_body(10'h155, 1'b1, 0);
    send_bit(1'b1);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_data", out_data, 10'h2A5);
    chk("ovr_flag", overrun, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ovr_drain", out_valid, 0);
    chk("ovr_sticky", overrun, 1);
    do_reset();
    chk("ovr_rst", overrun, 0);

    // reset mid-frame discards the partial frame
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    chk("mrst_busy", busy, 1);
    do_reset();
    chk("mrst_idle", busy, 0);
    chk("mrst_novalid", out_valid, 0);
    send_body(10'h155, 1'b1, 0);
    send_bit(1'b1);
    chk("mrst_valid", out_valid, 1);
    chk("mrst_data", out_data, 10'h155);
    chk("mrst_perr", par_err, 0);
    chk("mrst_ferr", frame_err, 0);
`ifdef FRAME_PARITY_RX_ERRCNT_EN
    chk("mrst_errcnt", err_count, exp_err);
`endif
    out_ready = 1'b1;
    tick();
    chk("mrst_drain", out_valid, 0);

    // random bit_en gaps with consumer always ready
    send_body(10'h0F0, 1'b0, 3);
    gap(3);
    send_bit(1'b1);
    vcnt = 0;
    if (out_valid) vcnt++;
    chk("gap_data", out_data, 10'h0F0);
    chk("gap_perr", par_err, 0);
    repeat (5) begin
      tick();
      if (out_valid) vcnt++;
    end
    chk("gap_pulse", vcnt, 1);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
